// File: rtl/bomberman_pkg.sv
// Shared constants and types for the bomberman video path.
// Map geometry, register offsets and the map-update command format.
package bomberman_pkg;

  localparam int MAP_W = 40;
  localparam int MAP_H = 30;
  localparam int MAP_TILES = MAP_W * MAP_H;

  localparam logic [1:0] REG_PUSH = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  typedef struct packed {
    logic [3:0] tile;
    logic [10:0] maddr;
  } map_cmd_t;

  typedef enum logic [1:0] {
    MQ_IDLE,
    MQ_DRAIN,
    MQ_CLEAR
  } mq_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with pointers one bit wider than the index,
// so full and empty fall out of the pointer difference.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 15,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  input logic push,
  input logic [W-1:0] din,
  input logic pop,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic do_push;
  logic do_pop;

  assign level = wptr - rptr;
  assign empty = (level == '0);
  assign full = (level == (AW+1)'(DEPTH));
  assign do_pop = pop && !empty;
  // A push into a full FIFO is only taken when a pop frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/map_update_queue.sv
// Queues CPU tile updates and replays them into the map RAM
// only during vertical blanking; also performs bulk map clears.
module map_update_queue #(
  parameter int DEPTH = 16,
  parameter int MAP_TILES = 1200
) (
  input logic clk,
  input logic reset,
  input logic chipselect,
  input logic write,
  input logic read,
  input logic [1:0] address,
  input logic [15:0] writedata,
  output logic [15:0] readdata,
  input logic vblank,
  output logic [10:0] map_wraddress,
  output logic [7:0] map_data,
  output logic map_wren
);

  import bomberman_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [10:0] LAST = 11'(MAP_TILES - 1);

  logic wr;
  logic push;
  logic clear_req;
  logic flag_clr;
  logic pop;
  logic clear_wr;
  logic head_ok;
  logic full;
  logic empty;
  logic [LW-1:0] level;
  map_cmd_t head;
  mq_state_t state;
  mq_state_t next;
  logic [10:0] cnt;
  logic [3:0] fill;
  logic ovf;
  logic err;
  logic [15:0] status;

  assign wr = chipselect && write;
  assign push = wr && (address == REG_PUSH) && writedata[15];
  assign clear_req = wr && (address == REG_CTRL) && writedata[0];
  assign flag_clr = wr && (address == REG_CTRL) && writedata[1];
  assign head_ok = int'(head.maddr) < MAP_TILES;
  assign status = {8'd0, err, ovf, state == MQ_CLEAR, 5'(level)};

  cmd_fifo #(
    .DEPTH(DEPTH),
    .W($bits(map_cmd_t))
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(writedata[14:0]),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MQ_IDLE;
    else state <= next;
  end

  always_comb begin
    next = state;
    pop = 1'b0;
    clear_wr = 1'b0;
    unique case (state)
      MQ_IDLE: begin
        if (clear_req) next = MQ_CLEAR;
        else if (vblank && !empty) next = MQ_DRAIN;
      end
      MQ_DRAIN: begin
        pop = vblank && !empty;
        if (clear_req) next = MQ_CLEAR;
        else if (!vblank || empty) next = MQ_IDLE;
      end
      MQ_CLEAR: begin
        // A fresh clear request restarts the sweep instead of writing.
        clear_wr = vblank && !clear_req;
        if (clear_wr && cnt == LAST) next = MQ_IDLE;
      end
      default: next = MQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      fill <= '0;
    end else if (clear_req) begin
      cnt <= '0;
      fill <= writedata[4:1];
    end else if (clear_wr) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_wren <= 1'b0;
      map_wraddress <= '0;
      map_data <= '0;
    end else begin
      map_wren <= 1'b0;
      if (pop && head_ok) begin
        map_wren <= 1'b1;
        map_wraddress <= head.maddr;
        map_data <= {4'd0, head.tile};
      end else if (clear_wr) begin
        map_wren <= 1'b1;
        map_wraddress <= cnt;
        map_data <= {4'd0, fill};
      end
    end
  end

  // New events win over a flag clear arriving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      err <= 1'b0;
      readdata <= '0;
    end else begin
      if (flag_clr) begin
        ovf <= 1'b0;
        err <= 1'b0;
      end
      if (push && full && !pop) ovf <= 1'b1;
      if (pop && !head_ok) err <= 1'b1;
      if (chipselect && read)
        readdata <= (address == REG_STATUS) ? status : 16'd0;
    end
  end

endmodule
